// File: rtl/mult_div_unit.sv
// mult_div_unit -- iterative 32x32 multiply / divide unit for the execute stage.
//
// Computes MULT/MULTU products and DIV/DIVU quotient/remainder one radix-2 step
// per clock on operand magnitudes, then applies the sign correction. Results
// land in the architectural HI/LO registers. Latency is a fixed 34 cycles from
// an accepted start back to idle, independent of operand values.
//
// Build option: define MDU_DIV_EN to include the divide datapath. Without it,
// a start with op[1]=1 is ignored (no busy, no done, HI/LO untouched).
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst      in   1  asynchronous reset, active low
//   start    in   1  request an operation (sampled only while idle)
//   op       in   2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   opa      in  32  multiplicand / dividend
//   opb      in  32  multiplier / divisor
//   hilo_we  in   2  bit1 writes HI, bit0 writes LO from wdata (idle only)
//   wdata    in  32  data for hilo_we writes
//   busy     out  1  operation in flight
//   done     out  1  one-cycle pulse, HI/LO hold the new result
//   hi       out 32  HI register (product high word / remainder)
//   lo       out 32  LO register (product low word / quotient)
module mult_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic [1:0]  hilo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SIGN, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // Datapath: r_acc is {partial product, multiplier} for multiply and
  // {partial remainder, dividend/quotient} for divide.
  logic [63:0] r_acc;
  logic [31:0] r_b;
  logic        r_neg_res;

  logic        w_legal;
  logic        w_accept;
  logic        w_signed;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_step;
  logic [63:0] w_step;
  logic [63:0] w_prod;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  function automatic logic [31:0] cneg32(input logic neg, input logic [31:0] x);
    return neg ? (32'd0 - x) : x;
  endfunction

  function automatic logic [63:0] cneg64(input logic neg, input logic [63:0] x);
    return neg ? (64'd0 - x) : x;
  endfunction

`ifdef MDU_DIV_EN
  logic        r_is_div;
  logic        r_neg_rem;
  logic        r_ovf;
  logic [31:0] r_a_raw;
  logic [32:0] w_rem_sh;
  logic [32:0] w_rem_sub;
  logic        w_ge;
  logic [63:0] w_div_step;

  assign w_legal = 1'b1;
`else
  assign w_legal = ~op[1];
`endif

  assign w_accept = (r_state == S_IDLE) && start && w_legal;
  // op[0]=0 selects the signed variant for both MULT and DIV.
  assign w_signed = ~op[0];
  assign w_a_mag  = cneg32(w_signed & opa[31], opa);
  assign w_b_mag  = cneg32(w_signed & opb[31], opb);

  // Shift-add multiply: add multiplicand when the current multiplier bit is
  // set, then shift the whole 65-bit {carry, acc} right by one.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
  assign w_mul_step = {w_mul_sum, r_acc[31:1]};

`ifdef MDU_DIV_EN
  // Restoring divide: bring the next dividend bit into the remainder and
  // subtract the divisor if it fits. A kept remainder is always < divisor,
  // so it fits back into 32 bits.
  assign w_rem_sh   = r_acc[63:31];
  assign w_ge       = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_sub  = w_rem_sh - {1'b0, r_b};
  assign w_div_step = {(w_ge ? w_rem_sub[31:0] : w_rem_sh[31:0]), r_acc[30:0], w_ge};
  assign w_step     = r_is_div ? w_div_step : w_mul_step;
`else
  assign w_step     = w_mul_step;
`endif

  assign w_prod = cneg64(r_neg_res, r_acc);

  always_comb begin
    w_res_hi = w_prod[63:32];
    w_res_lo = w_prod[31:0];
`ifdef MDU_DIV_EN
    if (r_is_div) begin
      // Divide-by-zero and the single signed overflow case bypass the datapath.
      if (r_b == 32'd0) begin
        w_res_hi = r_a_raw;
        w_res_lo = 32'hFFFF_FFFF;
      end else if (r_ovf) begin
        w_res_hi = 32'd0;
        w_res_lo = 32'h8000_0000;
      end else begin
        w_res_hi = cneg32(r_neg_rem, r_acc[63:32]);
        w_res_lo = cneg32(r_neg_res, r_acc[31:0]);
      end
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == 6'd31) w_state_nxt = S_SIGN;
      S_SIGN:  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        if (w_accept) r_cnt <= 6'd0;
        if (hilo_we[1]) r_hi <= wdata;
        if (hilo_we[0]) r_lo <= wdata;
      end
      if (r_state == S_RUN) r_cnt <= r_cnt + 6'd1;
      if (r_state == S_SIGN) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  // Operand capture and iteration: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_acc     <= {32'd0, w_a_mag};
      r_b       <= w_b_mag;
      r_neg_res <= w_signed & (opa[31] ^ opb[31]);
`ifdef MDU_DIV_EN
      r_is_div  <= op[1];
      r_neg_rem <= w_signed & opa[31];
      r_ovf     <= (op == 2'b10) && (opa == 32'h8000_0000) && (opb == 32'hFFFF_FFFF);
      r_a_raw   <= opa;
`endif
    end else if (r_state == S_RUN) begin
      r_acc <= w_step;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
